// File: rtl/writeback_arbiter.sv
// ---------------------------------------------------------------------------
// writeback_arbiter
//
// Purpose
//   Shares the register file's single write port between N_REQ writeback
//   sources (slot 0 = ALU, slot 1 = load unit, ...). Requests are granted
//   round-robin, one per cycle. The winner is registered into the write port
//   with one cycle of latency. A scoreboard of destination registers with
//   writes still outstanding lets decode stall on RAW hazards.
//
// Parameters
//   N_REQ  number of writeback requesters (2..8)
//   XLEN   data width
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   req_valid[i]        requester i holds a result
//   req_ready[i]        requester i is granted this cycle (combinational)
//   req_rd              packed dest registers, slot i at [5i+4:5i]
//   req_data            packed results, slot i at [XLEN*i+XLEN-1:XLEN*i]
//   wb_rd/wb_data       registered register-file write address/data
//   wb_reg_write        registered register-file write enable
//   issue_valid/rd      decode marks issue_rd as having a write in flight
//   rs1, rs2            decode source operands to check
//   rs1_busy/rs2_busy   source has an outstanding write
//   pending             scoreboard vector, bit k = x_k pending
// ---------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int N_REQ = 2,
  parameter int XLEN  = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [5*N_REQ-1:0]      req_rd,
  input  logic [XLEN*N_REQ-1:0]   req_data,
  output logic [4:0]              wb_rd,
  output logic [XLEN-1:0]         wb_data,
  output logic                    wb_reg_write,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic [31:0]             pending
);

  localparam int PW = $clog2(N_REQ);

  // Per-slot views of the flat request buses.
  logic [N_REQ-1:0][4:0]      rd_arr;
  logic [N_REQ-1:0][XLEN-1:0] data_arr;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign rd_arr[i]   = req_rd[5*i +: 5];
    assign data_arr[i] = req_data[XLEN*i +: XLEN];
  end

  // -------------------------------------------------------------------------
  // Round-robin selection: walk the slots starting at rr_ptr, wrapping at
  // N_REQ (which need not be a power of two), and take the first valid one.
  // -------------------------------------------------------------------------
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   sel;
  logic [PW:0]     idx;
  logic            win_found;
  logic [N_REQ-1:0] grant;

  always_comb begin
    grant     = '0;
    win       = '0;
    win_found = 1'b0;
    idx       = '0;
    sel       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N_REQ)) idx = idx - (PW+1)'(N_REQ);
      sel = idx[PW-1:0];
      if (!win_found && req_valid[sel]) begin
        win_found  = 1'b1;
        win        = sel;
        grant[sel] = 1'b1;
      end
    end
  end

  // No grants are offered while reset is held, so nothing is lost upstream.
  assign req_ready = reset ? '0 : grant;

  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;
  logic [PW-1:0]   ptr_nxt;

  assign win_rd   = rd_arr[win];
  assign win_data = data_arr[win];
  assign ptr_nxt  = (win == PW'(N_REQ-1)) ? '0 : win + PW'(1);

  // -------------------------------------------------------------------------
  // Scoreboard next state. Clear for the retiring write is applied first so a
  // same-cycle issue of the same rd leaves it pending: the newer writer is
  // still outstanding. x0 is never tracked.
  // -------------------------------------------------------------------------
  logic [31:0] pend_nxt;

  always_comb begin
    pend_nxt = pending;
    if (win_found) pend_nxt[win_rd] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) pend_nxt[issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // -------------------------------------------------------------------------
  // Output register, pointer and scoreboard state.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_reg_write <= 1'b0;
      pending      <= '0;
      rr_ptr       <= '0;
    end else begin
      pending <= pend_nxt;
      if (win_found) begin
        wb_rd        <= win_rd;
        wb_data      <= win_data;
        // A write to x0 still consumes the grant but never strobes the file.
        wb_reg_write <= (win_rd != 5'd0);
        rr_ptr       <= ptr_nxt;
      end else begin
        wb_reg_write <= 1'b0;
      end
    end
  end

  // The file writes mid-cycle, so a bit cleared at this edge is safe to read
  // as not-busy in the following cycle.
  assign rs1_busy = (rs1 != 5'd0) && pending[rs1];
  assign rs2_busy = (rs2 != 5'd0) && pending[rs2];

endmodule
